// File: rtl/sample_feeder.sv
// sample_feeder: buffers host samples in a small FIFO and hands them one at a
// time to the FIR datapath using a data_ready / modwait handshake. Emits one
// sample_done per finished sample and stops after BLOCK_SIZE samples.
module sample_feeder #(
  parameter int unsigned BLOCK_SIZE  = 1000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          wr_en,
  input  logic [15:0]                   wr_data,
  input  logic                          modwait,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          data_ready,
  output logic [15:0]                   sample_data,
  output logic                          sample_done,
  output logic [9:0]                    remaining,
  output logic                          busy,
  output logic                          block_done,
  output logic                          err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitAck,
    StWaitDone,
    StDone
  } state_e;

  state_e          state_q;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] ack_cnt_q;
  logic            push;
  logic            pop;

  assign fifo_full = (fifo_count == (PtrW + 1)'(FIFO_DEPTH));
  assign busy      = (state_q != StIdle);

  // Head is consumed only on the transition into issuing a sample.
  assign pop  = (state_q == StLoad) && (fifo_count != '0) && !modwait && !abort;
  // A write into a full FIFO is still taken when the head leaves on the same edge,
  // so occupancy stays constant under a simultaneous read and write.
  assign push = wr_en && (!fifo_full || pop) && !abort;

  // FIFO pointers and occupancy; abort flushes in any state.
  always_ff @(posedge clk) begin
    if (!n_rst || abort) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Issue FSM with registered strobes, block counter and sticky timeout error.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      sample_data <= '0;
      data_ready  <= 1'b0;
      sample_done <= 1'b0;
      block_done  <= 1'b0;
      remaining   <= '0;
      err         <= 1'b0;
      ack_cnt_q   <= '0;
    end else begin
      data_ready  <= 1'b0;
      sample_done <= 1'b0;
      block_done  <= 1'b0;
      if (abort) begin
        // Any FIR operation still in flight is simply forgotten.
        if (state_q != StIdle) begin
          state_q   <= StIdle;
          remaining <= '0;
        end
      end else begin
        case (state_q)
          StIdle: begin
            if (start) begin
              state_q   <= StLoad;
              remaining <= 10'(BLOCK_SIZE);
              err       <= 1'b0;
            end
          end
          StLoad: begin
            // An empty FIFO is a legal stall, not an error.
            if (pop) begin
              sample_data <= mem_q[rd_ptr_q];
              data_ready  <= 1'b1;
              ack_cnt_q   <= '0;
              state_q     <= StWaitAck;
            end
          end
          StWaitAck: begin
            if (modwait) begin
              state_q <= StWaitDone;
            end else if (ack_cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
              err     <= 1'b1;
              state_q <= StIdle;
            end else begin
              ack_cnt_q <= ack_cnt_q + 1'b1;
            end
          end
          StWaitDone: begin
            if (!modwait) begin
              sample_done <= 1'b1;
              if (remaining > 10'd1) begin
                remaining <= remaining - 1'b1;
                state_q   <= StLoad;
              end else begin
                remaining <= '0;
                state_q   <= StDone;
              end
            end
          end
          StDone: begin
            block_done <= 1'b1;
            state_q    <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder: directed stimulus for a small-block instance checked every
// cycle against a queue-based model, plus a BLOCK_SIZE=1000 instance checked
// by event counts and issued-data ordering.
module tb_sample_feeder;

  localparam int unsigned Blk   = 3;
  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Small-block instance
  logic        n_rst, start, abort, wr_en, modwait;
  logic [15:0] wr_data;
  logic        fifo_full, data_ready, sample_done, busy, block_done, err;
  logic [2:0]  fifo_count;
  logic [15:0] sample_data;
  logic [9:0]  remaining;
  logic        fir_en, fir_mw, man_mw;
  assign modwait = fir_mw | man_mw;

  sample_feeder #(.BLOCK_SIZE(Blk), .FIFO_DEPTH(Depth), .ACK_TIMEOUT(Tmo)) u_dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .wr_en(wr_en),
    .wr_data(wr_data), .modwait(modwait), .fifo_full(fifo_full), .fifo_count(fifo_count),
    .data_ready(data_ready), .sample_data(sample_data), .sample_done(sample_done),
    .remaining(remaining), .busy(busy), .block_done(block_done), .err(err)
  );

  // Full-size instance
  logic        b_n_rst, b_start, b_wr_en, b_mw;
  logic [15:0] b_wr_data;
  logic        b_full, b_dr, b_sd, b_busy, b_bd, b_err;
  logic [2:0]  b_cnt;
  logic [15:0] b_data;
  logic [9:0]  b_rem;

  sample_feeder #(.BLOCK_SIZE(1000), .FIFO_DEPTH(Depth), .ACK_TIMEOUT(Tmo)) u_big (
    .clk(clk), .n_rst(b_n_rst), .start(b_start), .abort(1'b0), .wr_en(b_wr_en),
    .wr_data(b_wr_data), .modwait(b_mw), .fifo_full(b_full), .fifo_count(b_cnt),
    .data_ready(b_dr), .sample_data(b_data), .sample_done(b_sd),
    .remaining(b_rem), .busy(b_busy), .block_done(b_bd), .err(b_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the small instance ----------------
  typedef enum int {MIdle, MFetch, MAck, MRun, MEnd} mph_e;
  int unsigned mq[$];
  mph_e        mph = MIdle;
  int          m_age, m_rem;
  bit          m_err, m_dr, m_sd, m_bd;
  int unsigned m_data;
  bit          mdl_valid = 1'b0;

  always @(posedge clk) begin : mdl
    int  sz;
    bit  take;
    m_dr = 1'b0;
    m_sd = 1'b0;
    m_bd = 1'b0;
    if (!n_rst) begin
      mq.delete();
      mph = MIdle; m_rem = 0; m_data = 0; m_err = 1'b0; mdl_valid = 1'b1;
    end else if (abort) begin
      mq.delete();
      if (mph != MIdle) begin mph = MIdle; m_rem = 0; end
    end else begin
      sz   = mq.size();
      take = (mph == MFetch) && (sz > 0) && !modwait;
      if (take) m_data = mq.pop_front();
      if (wr_en && (sz < Depth || take)) mq.push_back(int'(wr_data));
      case (mph)
        MIdle:  if (start) begin mph = MFetch; m_rem = Blk; m_err = 1'b0; end
        MFetch: if (take) begin m_dr = 1'b1; m_age = 0; mph = MAck; end
        MAck: begin
          m_age++;
          if (modwait) mph = MRun;
          else if (m_age >= Tmo) begin m_err = 1'b1; mph = MIdle; end
        end
        MRun: if (!modwait) begin
          m_sd  = 1'b1;
          m_rem = (m_rem > 0) ? m_rem - 1 : 0;
          mph   = (m_rem == 0) ? MEnd : MFetch;
        end
        MEnd: begin m_bd = 1'b1; mph = MIdle; end
        default: mph = MIdle;
      endcase
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (mdl_valid) begin
      chk("fifo_count", fifo_count, mq.size());
      chk("fifo_full", fifo_full, mq.size() == Depth);
      chk("data_ready", data_ready, m_dr);
      chk("sample_data", sample_data, m_data);
      chk("sample_done", sample_done, m_sd);
      chk("remaining", remaining, m_rem);
      chk("busy", busy, mph != MIdle);
      chk("block_done", block_done, m_bd);
      chk("err", err, m_err);
    end
  end

  // Event logs for the hand-computed checks
  int unsigned dr_log[$];
  int unsigned rem_log[$];
  int sd_cnt, bd_cnt, cyc, last_dr_cyc, prev_dr_cyc, last_sd_cyc, last_bd_cyc;
  always @(negedge clk) begin
    cyc++;
    if (data_ready) begin
      dr_log.push_back(int'(sample_data));
      prev_dr_cyc = last_dr_cyc;
      last_dr_cyc = cyc;
    end
    if (sample_done) begin sd_cnt++; rem_log.push_back(int'(remaining)); last_sd_cyc = cyc; end
    if (block_done) begin bd_cnt++; last_bd_cyc = cyc; end
  end

  // FIR stand-in: modwait high for fir_len cycles starting one cycle after data_ready
  int fir_k;
  bit fir_act;
  int fir_len = 5;
  always @(negedge clk) begin
    if (fir_act) begin
      fir_k++;
      fir_mw = (fir_k <= fir_len);
      if (fir_k > fir_len) fir_act = 1'b0;
    end
    if (fir_en && data_ready) begin fir_act = 1'b1; fir_k = 0; end
  end

  // Big instance: FIR stand-in (2 busy cycles), host feeder, data/event checker
  int bf_k;
  bit bf_act;
  always @(negedge clk) begin
    if (!b_n_rst) begin
      bf_act = 1'b0;
      b_mw   = 1'b0;
    end else begin
      if (bf_act) begin
        bf_k++;
        b_mw = (bf_k <= 2);
        if (bf_k > 2) bf_act = 1'b0;
      end
      if (b_dr) begin bf_act = 1'b1; bf_k = 0; end
    end
  end

  bit          b_feed, b_chk_data;
  int unsigned b_val, b_exp;
  int          b_sd_cnt, b_bd_cnt;
  always @(negedge clk) begin
    if (b_wr_en) b_val++;  // only issued when not full, so it was accepted
    b_wr_en   = b_feed && (b_cnt < 3'(Depth));
    b_wr_data = b_val[15:0];
    if (b_dr) begin
      if (b_chk_data) chk("big_data", b_data, b_exp[15:0]);
      b_exp++;
    end
    if (b_sd) b_sd_cnt++;
    if (b_bd) b_bd_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic pclk();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [15:0] d);
    wr_en = 1'b1; wr_data = d;
    pclk();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    pclk();
    start = 1'b0;
  endtask

  task automatic clear_logs();
    dr_log.delete(); rem_log.delete(); sd_cnt = 0; bd_cnt = 0;
  endtask

  task automatic wait_block(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      pclk();
      if (block_done) ok = 1'b1;
    end
    chk(name, ok, 1'b1);
    pclk();
  endtask

  task automatic chk_seq(input string name, input int unsigned e0, e1, e2);
    int unsigned e[3];
    e = '{e0, e1, e2};
    chk({name, "_n"}, dr_log.size(), 3);
    for (int i = 0; i < 3 && i < dr_log.size(); i++)
      chk($sformatf("%s_%0d", name, i), dr_log[i], e[i]);
  endtask

  initial begin : stim
    bit ok;
    int n;
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; wr_en = 1'b0; wr_data = '0;
    man_mw = 1'b0; fir_en = 1'b0; fir_mw = 1'b0; fir_act = 1'b0;
    b_n_rst = 1'b0; b_start = 1'b0; b_wr_en = 1'b0; b_wr_data = '0; b_mw = 1'b0;
    b_feed = 1'b0; b_chk_data = 1'b0; b_val = 0; b_exp = 0; b_sd_cnt = 0; b_bd_cnt = 0;
    repeat (2) pclk();
    chk("rst_busy", busy, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_err", err, 0);
    chk("rst_big_rem", b_rem, 0);
    n_rst = 1'b1; b_n_rst = 1'b1;
    pclk();

    // Basic three-sample block
    clear_logs();
    write(16'h0011); write(16'h0022); write(16'h0033);
    chk("t1_cnt", fifo_count, 3);
    fir_en = 1'b1;
    pulse_start();
    chk("t1_rem0", remaining, 3);
    chk("t1_dr_early", data_ready, 0);
    pclk();
    chk("t1_dr_first", data_ready, 1);
    chk("t1_data_first", sample_data, 16'h0011);
    wait_block("t1_block_done");
    chk_seq("t1_dr", 16'h0011, 16'h0022, 16'h0033);
    chk("t1_sd", sd_cnt, 3);
    chk("t1_bd", bd_cnt, 1);
    chk("t1_rem_seq", {rem_log.size() == 3 ? rem_log[0] : 99, 8'h00}, {32'd2, 8'h00});
    chk("t1_rem_last", rem_log.size() == 3 ? rem_log[2] : 99, 0);
    chk("t1_period", last_dr_cyc - prev_dr_cyc, 8);
    chk("t1_bd_after_sd", last_bd_cyc - last_sd_cyc, 1);
    chk("t1_busy_end", busy, 0);

    // Full FIFO, dropped write, then pop-with-write at full
    clear_logs();
    write(16'h0101); write(16'h0202); write(16'h0303); write(16'h0404);
    chk("t2_full", fifo_full, 1);
    write(16'hDEAD);
    chk("t2_cnt4", fifo_count, 4);
    pulse_start();
    wr_en = 1'b1; wr_data = 16'h0505;
    pclk();
    wr_en = 1'b0;
    chk("t2_cnt_same", fifo_count, 4);
    chk("t2_dr", data_ready, 1);
    wait_block("t2_block_done");
    chk_seq("t2_dr", 16'h0101, 16'h0202, 16'h0303);
    chk("t2_left", fifo_count, 2);

    // Empty-FIFO stall in the middle of a block
    clear_logs();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      pclk();
      if (sd_cnt == 2) ok = 1'b1;
    end
    chk("t3_two_done", ok, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      pclk();
      if (data_ready) n++;
    end
    chk("t3_stall_dr", n, 0);
    chk("t3_stall_err", err, 0);
    chk("t3_stall_busy", busy, 1);
    chk("t3_stall_rem", remaining, 1);
    write(16'h0606);
    chk("t3_cnt1", fifo_count, 1);
    chk("t3_dr_not_yet", data_ready, 0);
    pclk();
    chk("t3_dr", data_ready, 1);
    chk("t3_data", sample_data, 16'h0606);
    wait_block("t3_block_done");
    chk_seq("t3_dr", 16'h0404, 16'h0505, 16'h0606);

    // Acknowledge timeout
    fir_en = 1'b0;
    write(16'h0707);
    pulse_start();
    pclk();
    chk("t4_dr", data_ready, 1);
    repeat (7) pclk();
    chk("t4_err_early", err, 0);
    pclk();
    chk("t4_err", err, 1);
    chk("t4_busy", busy, 0);
    chk("t4_rem", remaining, 3);
    pulse_start();
    chk("t4_err_clr", err, 0);
    chk("t4_busy2", busy, 1);
    abort = 1'b1;
    pclk();
    abort = 1'b0;
    chk("t4_abort_rem", remaining, 0);

    // Abort while the FIR is busy
    clear_logs();
    write(16'h0808); write(16'h0909); write(16'h0A0A);
    pulse_start();
    pclk();
    man_mw = 1'b1;
    repeat (2) pclk();
    chk("t5_cnt", fifo_count, 2);
    chk("t5_busy", busy, 1);
    abort = 1'b1;
    pclk();
    abort = 1'b0;
    chk("t5_busy0", busy, 0);
    chk("t5_cnt0", fifo_count, 0);
    chk("t5_rem0", remaining, 0);
    repeat (2) pclk();
    man_mw = 1'b0;
    repeat (10) pclk();
    chk("t5_no_sd", sd_cnt, 0);
    chk("t5_no_bd", bd_cnt, 0);

    // Full-size block: reset mid-block, then a complete run
    b_feed = 1'b1;
    b_start = 1'b1; pclk(); b_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      pclk();
      if (b_rem == 10'd500) ok = 1'b1;
    end
    chk("t6_reach500", ok, 1);
    b_feed = 1'b0; b_n_rst = 1'b0;
    pclk();
    b_n_rst = 1'b1;
    chk("t6_rst_busy", b_busy, 0);
    chk("t6_rst_rem", b_rem, 0);
    chk("t6_rst_cnt", b_cnt, 0);
    chk("t6_rst_full", b_full, 0);
    chk("t6_rst_dr", b_dr, 0);
    chk("t6_rst_data", b_data, 0);
    chk("t6_rst_sd", b_sd, 0);
    chk("t6_rst_bd", b_bd, 0);
    chk("t6_rst_err", b_err, 0);
    pclk();
    b_sd_cnt = 0; b_bd_cnt = 0; b_exp = b_val; b_chk_data = 1'b1; b_feed = 1'b1;
    b_start = 1'b1; pclk(); b_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      pclk();
      if (b_bd) ok = 1'b1;
    end
    chk("t6_block_done", ok, 1);
    b_feed = 1'b0;
    repeat (3) pclk();
    chk("t6_sd_total", b_sd_cnt, 1000);
    chk("t6_bd_total", b_bd_cnt, 1);
    chk("t6_busy_end", b_busy, 0);
    chk("t6_rem_end", b_rem, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
